// File: rtl/igniter_sequencer.sv
// igniter_sequencer: drives the igniter position block with bounded signed
// steps until the fed-back position equals the commanded target. Each jump is
// a one-cycle enable_jump pulse followed by a settle wait before re-reading.
// Outputs are all registered; done pulses on success, fault is sticky until
// the next accepted command.
module igniter_sequencer #(
  parameter int MAX_STEP      = 2,
  parameter int MAX_JUMPS     = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       sys_clk,
  input  logic       clr_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] target,
  input  logic [2:0] position,
  output logic [3:0] delta,
  output logic       enable_jump,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIRE,
    S_SETTLE,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic signed [3:0] STEP_POS    = 4'(MAX_STEP);
  localparam logic signed [3:0] STEP_NEG    = -STEP_POS;
  localparam logic        [3:0] JUMP_LIMIT  = 4'(MAX_JUMPS);
  localparam logic        [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t            state_reg;
  logic [2:0]        tgt_reg;
  logic [3:0]        jump_cnt_reg;
  logic [3:0]        settle_cnt_reg;
  logic [2:0]        diff;
  logic signed [3:0] offset;
  logic signed [3:0] step;

  // Shortest signed path to the target (tie at 4 goes positive), clamped.
  always_comb begin
    diff   = tgt_reg - position;
    offset = (diff <= 3'd4) ? $signed({1'b0, diff}) : $signed({1'b1, diff});
    step   = offset;
    if (offset > STEP_POS) begin
      step = STEP_POS;
    end else if (offset < STEP_NEG) begin
      step = STEP_NEG;
    end
  end

  // Sequencer FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg      <= S_IDLE;
      tgt_reg        <= 3'd0;
      jump_cnt_reg   <= 4'd0;
      settle_cnt_reg <= 4'd0;
      delta          <= 4'b0000;
      enable_jump    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      fault          <= 1'b0;
    end else begin
      enable_jump <= 1'b0;
      delta       <= 4'b0000;
      done        <= 1'b0;
      if (abort && (state_reg != S_IDLE)) begin
        // Cancel: back to idle with no done pulse; fault keeps its value.
        state_reg <= S_IDLE;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start && !abort) begin
              tgt_reg      <= target;
              jump_cnt_reg <= 4'd0;
              fault        <= 1'b0;
              busy         <= 1'b1;
              state_reg    <= S_CALC;
            end
          end
          S_CALC: begin
            if (diff == 3'd0) begin
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else if (jump_cnt_reg == JUMP_LIMIT) begin
              fault     <= 1'b1;
              busy      <= 1'b0;
              state_reg <= S_FAULT;
            end else begin
              delta       <= step;
              enable_jump <= 1'b1;
              state_reg   <= S_FIRE;
            end
          end
          S_FIRE: begin
            jump_cnt_reg   <= jump_cnt_reg + 4'd1;
            settle_cnt_reg <= SETTLE_LOAD;
            state_reg      <= S_SETTLE;
          end
          S_SETTLE: begin
            settle_cnt_reg <= settle_cnt_reg - 4'd1;
            if (settle_cnt_reg == 4'd1) begin
              state_reg <= S_CALC;
            end
          end
          S_DONE: begin
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end
          S_FAULT: begin
            state_reg <= S_IDLE;
          end
          default: begin
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_igniter_sequencer.sv
// Testbench for igniter_sequencer: table of directed commands, hand-written
// abort/reset sequences, then random commands with busy-time noise, all
// checked against a step-list model of the igniter behaviour.
module tb_igniter_sequencer;

  localparam int MAX_STEP      = 2;
  localparam int MAX_JUMPS     = 4;
  localparam int SETTLE_CYCLES = 2;

  logic       sys_clk = 1'b0;
  logic       clr_n;
  logic       start;
  logic       abort;
  logic [2:0] target;
  logic [2:0] pos;
  logic [3:0] delta;
  logic       enable_jump;
  logic       busy;
  logic       done;
  logic       fault;

  logic       load_req;
  logic [2:0] load_val;
  logic       stuck;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 sys_clk = ~sys_clk;

  igniter_sequencer #(
    .MAX_STEP     (MAX_STEP),
    .MAX_JUMPS    (MAX_JUMPS),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .sys_clk    (sys_clk),
    .clr_n      (clr_n),
    .start      (start),
    .abort      (abort),
    .target     (target),
    .position   (pos),
    .delta      (delta),
    .enable_jump(enable_jump),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  // Igniter model: moves by delta on each jump unless it is stuck.
  always @(posedge sys_clk) begin
    if (load_req) pos <= load_val;
    else if (enable_jump && !stuck) pos <= pos + delta[2:0];
  end

  typedef struct {
    logic [2:0] p;
    logic [2:0] t;
    bit         stk;
    int         jumps;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_pos(input logic [2:0] p, input bit stk);
    @(negedge sys_clk);
    load_val = p;
    load_req = 1'b1;
    stuck    = stk;
    @(negedge sys_clk);
    load_req = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] p, input logic [2:0] t, input bit stk,
                         input bit noise, input int exp_j);
    int pp, dd, off, n, ef, endc;
    int no, consec, idle_d, done_cnt, done_c, busy_cnt, fault_c, f1, fl, seq_bad;
    logic [3:0] ed[16];
    logic [3:0] od[16];
    int         oc[16];
    logic       last_ej;
    // Reference: list of clamped shortest-path steps the igniter should see.
    pp = int'(p); n = 0; ef = 0;
    for (int i = 0; i <= MAX_JUMPS; i++) begin
      dd = ((int'(t) - pp) % 8 + 8) % 8;
      if (dd == 0) break;
      if (n == MAX_JUMPS) begin
        ef = 1;
        break;
      end
      off = (dd <= 4) ? dd : dd - 8;
      if (off > MAX_STEP) off = MAX_STEP;
      if (off < -MAX_STEP) off = -MAX_STEP;
      ed[n] = 4'(off);
      n++;
      if (!stk) pp = (pp + off + 8) % 8;
    end
    endc = 2 + n * (2 + SETTLE_CYCLES);

    load_pos(p, stk);
    target = t;
    start  = 1'b1;
    no = 0; consec = 0; idle_d = 0; done_cnt = 0; done_c = 0;
    busy_cnt = 0; fault_c = 0; f1 = 0; fl = 0; last_ej = 1'b0;
    for (int k = 1; k <= endc + 4; k++) begin
      @(negedge sys_clk);
      if (enable_jump) begin
        if (last_ej) consec++;
        if (no < 16) begin
          oc[no] = k;
          od[no] = delta;
        end
        no++;
      end else if (delta != 4'b0000) begin
        idle_d++;
      end
      last_ej = enable_jump;
      if (done) begin
        done_cnt++;
        done_c = k;
      end
      if (busy) busy_cnt++;
      if (fault && fault_c == 0) fault_c = k;
      if (k == 1) f1 = int'(fault);
      fl = int'(fault);
      if (noise && k < endc) begin
        start  = 1'($urandom % 2);
        target = 3'($urandom % 8);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;

    if (exp_j >= 0) check("jumps_table", no, exp_j);
    check("jumps_model", no, n);
    seq_bad = 0;
    for (int i = 0; i < n && i < no && i < 16; i++) begin
      if (oc[i] != 2 + i * (2 + SETTLE_CYCLES)) seq_bad++;
      if (od[i] != ed[i]) seq_bad++;
    end
    check("jump_seq", seq_bad, 0);
    check("ej_consecutive", consec, 0);
    check("delta_nonzero_idle", idle_d, 0);
    check("done_count", done_cnt, ef ? 0 : 1);
    check("done_cycle", done_c, ef ? 0 : endc);
    check("busy_cycles", busy_cnt, ef ? endc - 1 : endc);
    check("fault_cycle", fault_c, ef ? endc : 0);
    check("fault_cleared_on_start", f1, 0);
    check("fault_held", fl, ef);
    check("final_pos", int'(pos), pp);
    $display("cmd pos=%0d tgt=%0d stuck=%0d jumps=%0d done_at=%0d fault=%0d",
             p, t, stk, no, done_c, fl);
  endtask

  initial begin
    int cnt_done, cnt_ej, cnt_busy;
    clr_n = 1'b1; start = 1'b0; abort = 1'b0; target = 3'd0;
    load_req = 1'b0; load_val = 3'd0; stuck = 1'b0;

    vecs[0] = '{3'd1, 3'd3, 1'b0, 1};
    vecs[1] = '{3'd0, 3'd7, 1'b0, 1};
    vecs[2] = '{3'd0, 3'd4, 1'b0, 2};
    vecs[3] = '{3'd5, 3'd5, 1'b0, 0};
    vecs[4] = '{3'd0, 3'd2, 1'b1, 4};
    vecs[5] = '{3'd0, 3'd3, 1'b0, 2};
    vecs[6] = '{3'd6, 3'd1, 1'b0, 2};
    vecs[7] = '{3'd2, 3'd7, 1'b0, 2};
    vecs[8] = '{3'd7, 3'd3, 1'b0, 2};

    // Reset state
    #2 clr_n = 1'b0;
    #20;
    check("rst_delta", int'(delta), 0);
    check("rst_ej", int'(enable_jump), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fault", int'(fault), 0);
    @(negedge sys_clk);
    clr_n = 1'b1;
    $display("reset state checked");

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].p, vecs[i].t, vecs[i].stk, 1'b0, vecs[i].jumps);
    end

    // Abort during SETTLE
    load_pos(3'd0, 1'b0);
    target = 3'd4; start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    @(negedge sys_clk);
    check("abort_fire_ej", int'(enable_jump), 1);
    @(negedge sys_clk);
    check("abort_settle_busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_ej", int'(enable_jump), 0);
    cnt_done = 0; cnt_ej = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      if (done) cnt_done++;
      if (enable_jump) cnt_ej++;
    end
    check("abort_no_done", cnt_done, 0);
    check("abort_no_ej", cnt_ej, 0);
    check("abort_pos", int'(pos), 2);
    check("abort_fault", int'(fault), 0);
    $display("abort during settle: pos=%0d done_pulses=%0d", pos, cnt_done);

    // Abort and start together in IDLE
    @(negedge sys_clk);
    target = 3'd5; start = 1'b1; abort = 1'b1;
    @(negedge sys_clk);
    start = 1'b0; abort = 1'b0;
    cnt_busy = 0; cnt_ej = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy) cnt_busy++;
      if (enable_jump) cnt_ej++;
      @(negedge sys_clk);
    end
    check("abort_start_busy", cnt_busy, 0);
    check("abort_start_ej", cnt_ej, 0);
    $display("abort with start in idle: busy_cycles=%0d", cnt_busy);

    // Reset during SETTLE: outputs drop before the next edge
    load_pos(3'd0, 1'b0);
    target = 3'd4; start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1 clr_n = 1'b0;
    #1;
    check("rst_settle_busy", int'(busy), 0);
    check("rst_settle_delta", int'(delta), 0);
    check("rst_settle_ej", int'(enable_jump), 0);
    @(negedge sys_clk);
    clr_n = 1'b1;
    $display("reset during settle checked");

    // Reset during FIRE: the pending jump is dropped
    load_pos(3'd0, 1'b0);
    target = 3'd4; start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
    @(negedge sys_clk);
    check("rst_fire_pre_ej", int'(enable_jump), 1);
    check("rst_fire_pre_delta", int'(delta), 2);
    #1 clr_n = 1'b0;
    #1;
    check("rst_fire_ej", int'(enable_jump), 0);
    check("rst_fire_delta", int'(delta), 0);
    check("rst_fire_busy", int'(busy), 0);
    @(negedge sys_clk);
    clr_n = 1'b1;
    check("rst_fire_pos", int'(pos), 0);
    $display("reset during fire checked");

    // Random commands with start/target noise while busy
    for (int i = 0; i < 40; i++) begin
      run_cmd(3'($urandom % 8), 3'($urandom % 8), ($urandom % 6) == 0, 1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
